// File: rtl/noc_pkg.sv
// Shared types for the router output stage.
// VC count, VC index type and wormhole lock state.
package noc_pkg;

  localparam int NUM_VC = 2;

  typedef logic vc_t;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } lock_st_e;

endpackage

// File: rtl/noc_arb_rr.sv
// Round-robin arbiter with wormhole lock override.
// req/ptr/lock/lock_idx in, one-hot grant out.
module noc_arb_rr
  import noc_pkg::*;
#(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          lock,
  input  logic [PW-1:0] lock_idx,
  output logic [N-1:0]  grant
);

  int   j;
  logic found;

  always_comb begin
    grant = '0;
    j     = 0;
    found = 1'b0;
    if (lock) begin
      // Locked VC owns the output even on a bubble.
      grant[lock_idx] = 1'b1;
    end else begin
      for (int o = 0; o < N; o++) begin
        j = int'(ptr) + o;
        if (j >= N) j = j - N;
        if (!found && req[j]) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/noc_router_output.sv
// Output stage: per-VC wormhole RR arbitration, holding regs, VC link mux.
// in_* per VC per input; out_flit/out_last/out_valid/out_ready to the link.
module noc_router_output
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int INPUTS     = 5
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [1:0][INPUTS-1:0][FLIT_WIDTH-1:0]  in_flit,
  input  logic [1:0][INPUTS-1:0]                  in_last,
  input  logic [1:0][INPUTS-1:0]                  in_valid,
  output logic [1:0][INPUTS-1:0]                  in_ready,
  output logic [FLIT_WIDTH-1:0]                   out_flit,
  output logic                                    out_last,
  output logic [1:0]                              out_valid,
  input  logic [1:0]                              out_ready
);

  localparam int PW = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  lock_st_e                       st       [NUM_VC];
  logic [PW-1:0]                  rr_ptr   [NUM_VC];
  logic [PW-1:0]                  lock_idx [NUM_VC];

  logic [NUM_VC-1:0]                 hold_full;
  logic [NUM_VC-1:0]                 hold_last;
  logic [NUM_VC-1:0][FLIT_WIDTH-1:0] hold_flit;
  vc_t                               pref;

  logic [NUM_VC-1:0][INPUTS-1:0]     grant;
  logic [NUM_VC-1:0]                 rdy;
  logic [NUM_VC-1:0]                 acc;
  logic [NUM_VC-1:0]                 drain;
  logic [NUM_VC-1:0][PW-1:0]         sel_idx;
  logic [NUM_VC-1:0][FLIT_WIDTH-1:0] sel_flit;
  logic [NUM_VC-1:0]                 sel_last;
  logic [NUM_VC-1:0]                 cand;
  vc_t                               sel_vc;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_arb
    noc_arb_rr #(
      .N  (INPUTS),
      .PW (PW)
    ) u_arb (
      .req      (in_valid[g]),
      .ptr      (rr_ptr[g]),
      .lock     (st[g] == ST_LOCKED),
      .lock_idx (lock_idx[g]),
      .grant    (grant[g])
    );
  end

  always_comb begin
    in_ready = '0;
    rdy      = '0;
    acc      = '0;
    sel_idx  = '0;
    sel_flit = '0;
    sel_last = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      rdy[v]      = ~hold_full[v] | drain[v];
      in_ready[v] = grant[v] & {INPUTS{rdy[v]}};
      acc[v]      = |(in_valid[v] & in_ready[v]);
      for (int i = 0; i < INPUTS; i++) begin
        if (grant[v][i]) begin
          sel_idx[v]  = PW'(i);
          sel_flit[v] = in_flit[v][i];
          sel_last[v] = in_last[v][i];
        end
      end
    end
  end

  // A stalled VC is never offered, so it cannot block the other one.
  assign cand = hold_full & out_ready;

  always_comb begin
    sel_vc = pref;
    unique case (cand)
      2'b11:   sel_vc = pref;
      2'b01:   sel_vc = 1'b0;
      2'b10:   sel_vc = 1'b1;
      default: sel_vc = pref;
    endcase
    out_valid = '0;
    if (cand != '0) out_valid[sel_vc] = 1'b1;
    out_flit = hold_flit[sel_vc];
    out_last = hold_last[sel_vc];
  end

  assign drain = out_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_full <= '0;
      hold_last <= '0;
      hold_flit <= '0;
      pref      <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        st[v]       <= ST_IDLE;
        rr_ptr[v]   <= '0;
        lock_idx[v] <= '0;
      end
    end else begin
      if (|out_valid) pref <= ~sel_vc;
      for (int v = 0; v < NUM_VC; v++) begin
        if (acc[v]) begin
          hold_full[v] <= 1'b1;
          hold_flit[v] <= sel_flit[v];
          hold_last[v] <= sel_last[v];
          if (sel_last[v]) begin
            st[v] <= ST_IDLE;
            if (sel_idx[v] == PW'(INPUTS - 1))
              rr_ptr[v] <= '0;
            else
              rr_ptr[v] <= sel_idx[v] + 1'b1;
          end else begin
            st[v]       <= ST_LOCKED;
            lock_idx[v] <= sel_idx[v];
          end
        end else if (drain[v]) begin
          hold_full[v] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_router_output.sv
// Directed bench for noc_router_output.
// Drives after posedge, checks at negedge.
module tb_noc_router_output;

  logic                  clk;
  logic                  rst_n;
  logic [1:0][4:0][31:0] in_flit;
  logic [1:0][4:0]       in_last;
  logic [1:0][4:0]       in_valid;
  logic [1:0][4:0]       in_ready;
  logic [31:0]           out_flit;
  logic                  out_last;
  logic [1:0]            out_valid;
  logic [1:0]            out_ready;

  int n_run;
  int n_fail;

  noc_router_output #(
    .FLIT_WIDTH (32),
    .INPUTS     (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flit   (in_flit),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clr();
    in_flit  = '0;
    in_last  = '0;
    in_valid = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [4:0] rr_exp [6];
  int         rr_in  [6];

  initial begin
    n_run  = 0;
    n_fail = 0;
    clr();
    out_ready = 2'b11;
    rst_n     = 1'b0;
    tick();
    do_reset();

    settle();
    chk("rst_out_valid", out_valid, 2'b00);
    chk("rst_in_ready", in_ready, '0);
    tick();

    // single flit on VC0
    in_valid[0][2] = 1'b1;
    in_last[0][2]  = 1'b1;
    in_flit[0][2]  = 32'hA5A5_0001;
    settle();
    chk("t1_ready", in_ready[0], 5'b00100);
    tick();
    clr();
    settle();
    chk("t1_ov", out_valid, 2'b01);
    chk("t1_flit", out_flit, 32'hA5A5_0001);
    chk("t1_last", out_last, 1'b1);
    tick();
    in_valid[0] = 5'b10100;
    in_last[0]  = 5'b10100;
    settle();
    chk("t1_ptr3", in_ready[0], 5'b10000);
    tick();
    clr();
    tick();
    tick();

    // wormhole on VC1
    in_valid[1]    = 5'b01010;
    in_flit[1][1]  = 32'hB000_0001;
    in_flit[1][3]  = 32'hC000_0003;
    in_last[1][3]  = 1'b1;
    settle();
    chk("t2_c0_rdy", in_ready[1], 5'b00010);
    chk("t2_c0_ov", out_valid, 2'b00);
    tick();
    in_flit[1][1] = 32'hB000_0002;
    settle();
    chk("t2_c1_rdy", in_ready[1], 5'b00010);
    chk("t2_c1_ov", out_valid, 2'b10);
    chk("t2_c1_flit", out_flit, 32'hB000_0001);
    chk("t2_c1_last", out_last, 1'b0);
    tick();
    in_valid[1][1] = 1'b0;
    settle();
    chk("t2_c2_rdy", in_ready[1], 5'b00010);
    chk("t2_c2_flit", out_flit, 32'hB000_0002);
    tick();
    in_valid[1][1] = 1'b1;
    in_flit[1][1]  = 32'hB000_0003;
    settle();
    chk("t2_c3_rdy", in_ready[1], 5'b00010);
    chk("t2_c3_bubble", out_valid, 2'b00);
    tick();
    in_flit[1][1] = 32'hB000_0004;
    in_last[1][1] = 1'b1;
    settle();
    chk("t2_c4_rdy", in_ready[1], 5'b00010);
    chk("t2_c4_flit", out_flit, 32'hB000_0003);
    tick();
    in_valid[1][1] = 1'b0;
    settle();
    chk("t2_c5_rdy", in_ready[1], 5'b01000);
    chk("t2_c5_ov", out_valid, 2'b10);
    chk("t2_c5_flit", out_flit, 32'hB000_0004);
    chk("t2_c5_last", out_last, 1'b1);
    tick();
    in_valid[1][3] = 1'b0;
    settle();
    chk("t2_c6_flit", out_flit, 32'hC000_0003);
    chk("t2_c6_rdy", in_ready[1], 5'b00000);
    tick();
    clr();
    settle();
    chk("t2_c7_ov", out_valid, 2'b00);
    tick();

    // round robin on VC0
    rr_exp = '{5'b00001, 5'b00010, 5'b10000,
               5'b00001, 5'b00010, 5'b10000};
    rr_in  = '{0, 1, 4, 0, 1, 4};
    in_valid[0] = 5'b10011;
    in_last[0]  = 5'b10011;
    for (int i = 0; i < 5; i++) in_flit[0][i] = 32'hD000_0000 | i;
    for (int c = 0; c < 6; c++) begin
      settle();
      chk($sformatf("t3_rdy%0d", c), in_ready[0], rr_exp[c]);
      if (c > 0)
        chk($sformatf("t3_out%0d", c), out_flit,
            32'hD000_0000 | rr_in[c-1]);
      tick();
    end
    clr();
    settle();
    chk("t3_out6", out_flit, 32'hD000_0004);
    tick();

    // VC interleave
    do_reset();
    in_valid[0][0] = 1'b1;
    in_valid[1][0] = 1'b1;
    in_last[0][0]  = 1'b1;
    in_last[1][0]  = 1'b1;
    in_flit[0][0]  = 32'hE000_0000;
    in_flit[1][0]  = 32'hF000_0001;
    tick();
    for (int c = 1; c < 7; c++) begin
      settle();
      if (c % 2 == 1) begin
        chk($sformatf("t4_ov%0d", c), out_valid, 2'b01);
        chk($sformatf("t4_fl%0d", c), out_flit, 32'hE000_0000);
        chk($sformatf("t4_rd%0d", c),
            {in_ready[1][0], in_ready[0][0]}, 2'b01);
      end else begin
        chk($sformatf("t4_ov%0d", c), out_valid, 2'b10);
        chk($sformatf("t4_fl%0d", c), out_flit, 32'hF000_0001);
        chk($sformatf("t4_rd%0d", c),
            {in_ready[1][0], in_ready[0][0]}, 2'b10);
      end
      tick();
    end
    clr();
    tick();
    tick();
    tick();

    // VC isolation
    out_ready      = 2'b10;
    in_valid[0][1] = 1'b1;
    in_last[0][1]  = 1'b1;
    in_flit[0][1]  = 32'h1111_0000;
    in_valid[1][2] = 1'b1;
    in_last[1][2]  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_flit[1][2] = 32'h2222_0000 + c;
      settle();
      chk($sformatf("t5_ov%0d", c), out_valid,
          (c == 0) ? 2'b00 : 2'b10);
      if (c > 0)
        chk($sformatf("t5_fl%0d", c), out_flit, 32'h2222_0000 + c - 1);
      chk($sformatf("t5_rd0_%0d", c), in_ready[0],
          (c == 0) ? 5'b00010 : 5'b00000);
      tick();
      in_flit[0][1] = 32'h1111_0001;
    end
    out_ready     = 2'b11;
    in_flit[1][2] = 32'h2222_000A;
    settle();
    chk("t5_resume_ov", out_valid, 2'b01);
    chk("t5_resume_fl", out_flit, 32'h1111_0000);
    chk("t5_resume_rd", in_ready[0], 5'b00010);
    tick();
    clr();
    settle();
    chk("t5_next_ov", out_valid, 2'b10);
    chk("t5_next_fl", out_flit, 32'h2222_0009);
    tick();
    tick();
    tick();
    tick();

    // reset mid-packet
    in_valid[0][2] = 1'b1;
    in_flit[0][2]  = 32'h4444_0001;
    settle();
    chk("t6_c0_rdy", in_ready[0], 5'b00100);
    tick();
    in_flit[0][2] = 32'h4444_0002;
    settle();
    chk("t6_c1_rdy", in_ready[0], 5'b00100);
    chk("t6_c1_fl", out_flit, 32'h4444_0001);
    tick();
    in_flit[0][2] = 32'h4444_0003;
    do_reset();
    in_valid[0][0] = 1'b1;
    in_flit[0][0]  = 32'h5555_0000;
    settle();
    chk("t6_rst_ov", out_valid, 2'b00);
    chk("t6_rst_rdy", in_ready[0], 5'b00001);
    tick();
    clr();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
